// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions used by the MEM stage.
//   XLEN        datapath width
//   RES_MEM     ResultSrc encoding that selects load data in WB
//   mem_state_e MEM-stage data-memory access FSM states
//   ex_mem_s    contents of the EX/MEM pipeline register
//   is_mem_op   true when the M-stage instruction touches data memory
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RES_MEM = 2'b01;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_DONE
  } mem_state_e;

  typedef struct packed {
    logic            RegWrite;
    logic            MemWrite;
    logic [1:0]      ResultSrc;
    logic [4:0]      Rd;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] WriteData;
    logic [XLEN-1:0] PCPlus4;
  } ex_mem_s;

  // Loads are recognised by their write-back source; there is no separate MemRead.
  function automatic logic is_mem_op(ex_mem_s m);
    return m.MemWrite | (m.ResultSrc == RES_MEM);
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
//   clk, rst_n  clock and asynchronous active-low reset (reset = bubble)
//   en          capture d on the rising edge; hold otherwise
//   d           EX-stage bundle
//   q           M-stage bundle
module ex_mem_reg
  import riscv_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  ex_mem_s d,
  output ex_mem_s q
);

  // NOTE: state is written with non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RV32I pipeline.
//   Holds the EX/MEM register, drives a valid/ready data-memory request port
//   for lw/sw, stalls the pipeline while an access is outstanding, and
//   presents the M-stage bundle to WB and the forwarding/hazard logic.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   *E                         EX-stage control and data
//   dmem_req_*                 request channel (valid/ready handshake)
//   dmem_rvalid, dmem_rdata    load response (single-cycle pulse)
//   StallM                     hold F/D/E and EX/MEM
//   *M                         M-stage bundle to WB / forwarding
//   MisalignM, TimeoutM        sticky error flags
module memory_stage #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallM,
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] ReadDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic            MisalignM,
  output logic            TimeoutM
);

  import riscv_pkg::*;

  localparam int CW = $clog2(TIMEOUT);

  ex_mem_s         ex_bundle;
  ex_mem_s         m;
  mem_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hold_q;
  logic            mem_op;
  logic            stall;
  logic            req_valid;
  logic            timed_out;

  assign ex_bundle = '{
    RegWrite:  RegWriteE,
    MemWrite:  MemWriteE,
    ResultSrc: ResultSrcE,
    Rd:        RdE,
    ALUResult: ALUResultE,
    WriteData: WriteDataE,
    PCPlus4:   PCPlus4E
  };

  ex_mem_reg u_ex_mem_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .d     (ex_bundle),
    .q     (m)
  );

  assign mem_op = is_mem_op(m);

  // Last permitted WAIT cycle with no response yet.
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  // Stall depends only on FSM state, the M-stage opcode and req_ready; the
  // load response is registered into DONE first, so rvalid never reaches StallM.
  // NOTE: every signal assigned here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    stall     = 1'b0;
    req_valid = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      MS_IDLE: begin
        if (mem_op) begin
          req_valid = 1'b1;
          if (m.MemWrite) begin
            // An accepted store completes in the request cycle.
            stall = ~dmem_req_ready;
          end else begin
            stall = 1'b1;
            if (dmem_req_ready) state_d = MS_WAIT;
          end
        end
      end
      MS_WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid || timed_out) state_d = MS_DONE;
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MS_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      MisalignM <= 1'b0;
      TimeoutM  <= 1'b0;
    end else begin
      state_q <= state_d;
      // The counter only runs in WAIT, so it is zero on every WAIT entry.
      if (state_q == MS_WAIT) cnt_q <= cnt_q + CW'(1);
      else                    cnt_q <= '0;
      if (state_q == MS_WAIT) begin
        if (dmem_rvalid) begin
          hold_q <= dmem_rdata;
        end else if (timed_out) begin
          hold_q   <= '0;
          TimeoutM <= 1'b1;
        end
      end
      if (state_q == MS_IDLE && mem_op && (m.ALUResult[1:0] != 2'b00)) begin
        MisalignM <= 1'b1;
      end
    end
  end

  assign StallM         = stall;
  assign dmem_req_valid = req_valid;
  assign dmem_req_we    = m.MemWrite;
  assign dmem_req_addr  = {m.ALUResult[XLEN-1:2], 2'b00};
  assign dmem_req_wdata = m.WriteData;

  // Write-back is suppressed until the access has finished.
  assign RegWriteM  = m.RegWrite & ~stall;
  assign ResultSrcM = m.ResultSrc;
  assign RdM        = m.Rd;
  assign ALUResultM = m.ALUResult;
  assign PCPlus4M   = m.PCPlus4;
  assign ReadDataM  = hold_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage. The bench acts as the EX stage and
// the data memory; an instruction-level model predicts how long each
// instruction occupies M and what the stage must present while it is there.
module tb_memory_stage;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            RegWriteE, MemWriteE;
  logic [1:0]      ResultSrcE;
  logic [4:0]      RdE;
  logic [XLEN-1:0] ALUResultE, WriteDataE, PCPlus4E;
  logic            dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [XLEN-1:0] dmem_req_addr, dmem_req_wdata;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            StallM, RegWriteM, MisalignM, TimeoutM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] ALUResultM, ReadDataM, PCPlus4M;

  always #5 clk = ~clk;

  memory_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .MisalignM(MisalignM), .TimeoutM(TimeoutM)
  );

  // One instruction plus the memory behaviour it should see:
  // delay = cycles req_ready stays low, lat = cycles from acceptance to rvalid.
  typedef struct {
    bit          vld;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [31:0] rdata;
    int          delay;
    int          lat;
  } ins_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  ins_t        prog[$];
  ins_t        cur, nxt;
  int          age, wait_left, rv_cnt;
  logic [31:0] rv_data;
  bit          mis_s, to_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic ins_t idle();
    ins_t i = '{default: 0};
    return i;
  endfunction

  function automatic ins_t mk(logic rw, logic mw, logic [1:0] rs, logic [4:0] rd,
                              logic [31:0] alu, logic [31:0] wd, logic [31:0] pc4,
                              logic [31:0] rdata, int delay, int lat);
    ins_t i;
    i.vld = 1'b1; i.rw = rw; i.mw = mw; i.rs = rs; i.rd = rd; i.alu = alu;
    i.wd = wd; i.pc4 = pc4; i.rdata = rdata; i.delay = delay; i.lat = lat;
    return i;
  endfunction

  function automatic bit is_mem(ins_t i);
    return i.mw || (i.rs == 2'b01);
  endfunction

  function automatic bit is_load(ins_t i);
    return !i.mw && (i.rs == 2'b01);
  endfunction

  // Cycles the instruction spends in M: request phase, then for a load the
  // response wait (capped by the timeout) and one completion cycle.
  function automatic int occ(ins_t i);
    if (!is_mem(i)) return 1;
    if (i.mw)       return i.delay + 1;
    return i.delay + 1 + ((i.lat > TIMEOUT) ? TIMEOUT : i.lat) + 1;
  endfunction

  task automatic drive(input ins_t i);
    RegWriteE  = i.rw;
    MemWriteE  = i.mw;
    ResultSrcE = i.rs;
    RdE        = i.rd;
    ALUResultE = i.alu;
    WriteDataE = i.wd;
    PCPlus4E   = i.pc4;
  endtask

  task automatic model_reset();
    cur = idle(); nxt = idle(); age = 0; wait_left = 0; rv_cnt = -1;
    mis_s = 1'b0; to_s = 1'b0;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, advance the model.
  task automatic tick();
    bit last, mem, ld;
    @(negedge clk);
    drive(nxt);
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom();
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rv_data;
        rv_cnt      = -1;
      end
    end
    if (dmem_req_valid) begin
      dmem_req_ready = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      dmem_req_ready = 1'($urandom_range(0, 1));
    end
    #1;
    mem  = is_mem(cur);
    ld   = is_load(cur);
    last = (age == occ(cur) - 1);
    check("stall", StallM, !last);
    check("req_valid", dmem_req_valid, mem && (age <= cur.delay));
    if (mem && (age <= cur.delay)) begin
      check("req_we", dmem_req_we, cur.mw);
      check("req_addr", dmem_req_addr, cur.alu & 32'hFFFF_FFFC);
      if (cur.mw) check("req_wdata", dmem_req_wdata, cur.wd);
    end
    check("rd_m", RdM, cur.rd);
    check("alu_m", ALUResultM, cur.alu);
    check("res_src_m", ResultSrcM, cur.rs);
    check("regwrite_m", RegWriteM, cur.rw && last);
    if (last) begin
      check("pc4_m", PCPlus4M, cur.pc4);
      if (ld) check("read_data_m", ReadDataM, (cur.lat > TIMEOUT) ? 32'h0 : cur.rdata);
    end
    if (age == 0) begin
      check("misalign_m", MisalignM, mis_s);
      check("timeout_m", TimeoutM, to_s);
    end
    if (ld && age == cur.delay) begin
      rv_cnt  = cur.lat;
      rv_data = cur.rdata;
    end
    if (last) begin
      if (mem && cur.alu[1:0] != 2'b00) mis_s = 1'b1;
      if (ld && cur.lat > TIMEOUT)      to_s  = 1'b1;
      cur       = nxt;
      age       = 0;
      wait_left = cur.delay;
      nxt       = (prog.size() > 0) ? prog.pop_front() : idle();
    end else begin
      age++;
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((prog.size() > 0 || nxt.vld || cur.vld) && n < limit) begin
      tick();
      n++;
    end
    check("drain_bound", 32'(n < limit), 32'd1);
  endtask

  initial begin
    int k;
    bit found;
    rst_n          = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rvalid    = 1'b0;
    dmem_rdata     = '0;
    drive(idle());
    model_reset();
    #3;
    check("rst_stall", StallM, 0);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_regwrite", RegWriteM, 0);
    check("rst_alu", ALUResultM, 0);
    check("rst_read_data", ReadDataM, 0);
    check("rst_flags", {MisalignM, TimeoutM}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // sw 0x100 accepted at once; lw 0x104 answered two cycles after acceptance.
    prog.push_back(mk(0, 1, 2'b00, 5'd0, 32'h100, 32'hDEADBEEF, 32'h1004, 0, 0, 0));
    prog.push_back(mk(1, 0, 2'b01, 5'd5, 32'h104, 32'h0, 32'h1008, 32'h12345678, 0, 2));
    // sw held off for four cycles while an ALU op waits in EX.
    prog.push_back(mk(0, 1, 2'b00, 5'd0, 32'h200, 32'hA5A5A5A5, 32'h100C, 0, 4, 0));
    prog.push_back(mk(1, 0, 2'b00, 5'd9, 32'h3333, 32'h0, 32'h1010, 0, 0, 0));
    // Misaligned lw to 0x102.
    prog.push_back(mk(1, 0, 2'b01, 5'd6, 32'h102, 32'h0, 32'h1014, 32'h0BADF00D, 0, 1));
    prog.push_back(mk(1, 0, 2'b10, 5'd1, 32'h44, 32'h0, 32'h1018, 0, 0, 0));
    // lw whose response comes too late; the stray rvalid lands among the nops.
    prog.push_back(mk(1, 0, 2'b01, 5'd7, 32'h300, 32'h0, 32'h101C, 32'hCAFEF00D, 0, TIMEOUT + 5));
    for (int i = 0; i < 20; i++) prog.push_back(mk(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
    drain(2000);
    check("late_rvalid_ignored", ReadDataM, 32'h0);
    check("timeout_sticky", TimeoutM, 1);

    // Random instruction stream with random memory timing.
    for (int i = 0; i < 200; i++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a    = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case (kind)
        0: prog.push_back(mk(1'($urandom_range(0, 1)), 0,
                             ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                             5'($urandom()), a, $urandom(), $urandom(), 0, 0, 0));
        1: prog.push_back(mk(1, 0, 2'b01, 5'($urandom()), a, $urandom(), $urandom(),
                             $urandom(), $urandom_range(0, 3), $urandom_range(1, 6)));
        default: prog.push_back(mk(0, 1, 2'b00, 5'($urandom()), a, $urandom(), $urandom(),
                                   0, $urandom_range(0, 3), 0));
      endcase
    end
    drain(5000);

    // Reset while a load sits in WAIT; a response after reset must be ignored.
    prog.push_back(mk(1, 0, 2'b01, 5'd12, 32'h400, 32'h0, 32'h2000, 32'h11111111, 0, 1000));
    found = 1'b0;
    for (k = 0; k < 20 && !found; k++) begin
      tick();
      if (cur.vld && is_load(cur) && age == 3) found = 1'b1;
    end
    check("reached_wait", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_stall", StallM, 0);
    check("rst_wait_req_valid", dmem_req_valid, 0);
    check("rst_wait_regwrite", RegWriteM, 0);
    check("rst_wait_rd", RdM, 0);
    check("rst_wait_alu", ALUResultM, 0);
    check("rst_wait_addr", dmem_req_addr, 0);
    check("rst_wait_flags", {MisalignM, TimeoutM}, 0);
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0BAD0;
    #1;
    check("post_rst_stall", StallM, 0);
    check("post_rst_regwrite", RegWriteM, 0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("post_rst_read_data", ReadDataM, 0);
    check("post_rst_regwrite2", RegWriteM, 0);
    model_reset();

    prog.push_back(mk(1, 0, 2'b01, 5'd3, 32'h500, 32'h0, 32'h3000, 32'h76543210, 1, 3));
    prog.push_back(mk(1, 0, 2'b00, 5'd4, 32'h55, 32'h0, 32'h3004, 0, 0, 0));
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
